// File: rtl/de0_cken_gen_if.sv
// Configuration and strobe bus of the multi-channel clock-enable generator.
// The master writes increments and requests phase alignment; the slave returns the strobes and lock status.
interface de0_cken_gen_if #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [ACC_W-1:0]    wr_inc;
  logic                sync;
  logic [CHANNELS-1:0] ce;
  logic [CHANNELS-1:0] tgl;
  logic                locked;

  modport master (
    output wr_en, wr_ch, wr_inc, sync,
    input  ce, tgl, locked
  );

  modport slave (
    input  wr_en, wr_ch, wr_inc, sync,
    output ce, tgl, locked
  );
endinterface

// File: rtl/de0_cken_gen.sv
// Multi-channel fractional clock-enable generator built from per-channel phase accumulators,
// with run-time retuning, global phase alignment and a PLL-style lock indicator.
module de0_cken_gen #(
  parameter int                          CHANNELS    = 3,
  parameter int                          ACC_W       = 32,
  parameter int                          LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0]   INC_INIT    = {32'h0, 32'h8000_0000, 32'h4000_0000}
) (
  input  logic          clkin,
  input  logic          rst,
  de0_cken_gen_if.slave bus
);

  localparam int                CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int                LCNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CYCLES);

  logic [CHANNELS-1:0][ACC_W-1:0] acc;
  logic [CHANNELS-1:0][ACC_W-1:0] inc;
  logic [CHANNELS-1:0][ACC_W-1:0] sum;
  logic [CHANNELS-1:0]            carry;
  logic [CHANNELS-1:0]            ce_q;
  logic [CHANNELS-1:0]            tgl_q;
  logic [LCNT_W-1:0]              lcnt;
  logic [LCNT_W-1:0]              lcnt_next;
  logic                           locked_q;
  logic                           wr_valid;

  // Writes addressed past the last channel are dropped without disturbing the lock counter.
  assign wr_valid = bus.wr_en && (int'(bus.wr_ch) < CHANNELS);

  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  always_comb begin
    lcnt_next = lcnt;
    if (wr_valid || bus.sync) begin
      lcnt_next = '0;
    end else if (lcnt != LOCK_MAX) begin
      lcnt_next = lcnt + LCNT_W'(1);
    end
  end

  // The accumulator is never cleared on a write, so retuning keeps the phase continuous.
  always_ff @(posedge clkin) begin
    if (rst) begin
      acc      <= '0;
      inc      <= INC_INIT;
      ce_q     <= '0;
      tgl_q    <= '0;
      lcnt     <= '0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_valid && (bus.wr_ch == CH_W'(i))) begin
          inc[i] <= bus.wr_inc;
        end
        if (bus.sync) begin
          acc[i] <= '0;
        end else begin
          acc[i] <= sum[i];
        end
      end
      if (bus.sync) begin
        ce_q  <= '0;
        tgl_q <= '0;
      end else begin
        ce_q  <= carry;
        tgl_q <= tgl_q ^ carry;
      end
      lcnt     <= lcnt_next;
      locked_q <= (lcnt_next == LOCK_MAX);
    end
  end

  assign bus.ce     = ce_q;
  assign bus.tgl    = tgl_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_de0_cken_gen.sv
// Self-checking bench for de0_cken_gen: directed event table plus closed-form scoreboard on a
// 32-bit instance, and fractional-rate / near-full-scale checks on an 8-bit instance.
module tb_de0_cken_gen;

  localparam logic [31:0] QTR  = 32'h4000_0000;
  localparam logic [31:0] HALF = 32'h8000_0000;
  localparam int          NV   = 6;

  typedef struct {
    int          run;
    int          edge_n;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_inc;
    logic        sync;
    logic [2:0]  exp_ce;
    logic [2:0]  exp_tgl;
    logic        exp_locked;
  } vec_t;

  typedef struct {
    int         edge_n;
    logic [2:0] ce;
    logic [2:0] tgl;
    logic       locked;
  } exp_t;

  logic clkin = 1'b0;
  logic rst_a;
  logic rst_b;

  vec_t        vecs [NV];
  exp_t        sb [$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] init_a [3];
  logic [31:0] m_inc [3];
  int          m_align [3];
  int          m_restart;

  always #5 clkin = ~clkin;

  de0_cken_gen_if #(.CHANNELS(3), .ACC_W(32)) bus_a ();
  de0_cken_gen_if #(.CHANNELS(3), .ACC_W(8))  bus_b ();

  de0_cken_gen dut_a (
    .clkin (clkin),
    .rst   (rst_a),
    .bus   (bus_a)
  );

  de0_cken_gen #(
    .CHANNELS    (3),
    .ACC_W       (8),
    .LOCK_CYCLES (16),
    .INC_INIT    ({8'h00, 8'h80, 8'h00})
  ) dut_b (
    .clkin (clkin),
    .rst   (rst_b),
    .bus   (bus_b)
  );

  function automatic void check(input string name, input int run, input int e,
                                input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s run%0d edge%0d: got %0h, expected %0h", name, run, e, got, want);
    end
  endfunction

  // Closed-form prediction: a channel with a power-of-two increment pulses every 2^32/inc
  // edges counted from its last alignment point; lock holds 16 edges after the last restart.
  function automatic exp_t predict(input int e);
    exp_t x;
    int   p;
    int   n;
    x.edge_n = e;
    x.ce     = '0;
    x.tgl    = '0;
    for (int i = 0; i < 3; i++) begin
      if (m_inc[i] != 32'h0) begin
        p         = (m_inc[i] == QTR) ? 4 : 2;
        n         = e - m_align[i];
        x.ce[i]   = (n > 0) && ((n % p) == 0);
        x.tgl[i]  = ((n / p) % 2) == 1;
      end
    end
    x.locked = (e - m_restart) >= 16;
    return x;
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic applyStimulus(input int e, input logic r, input logic we, input logic [1:0] ch,
                               input logic [31:0] inc, input logic s);
    rst_a        = r;
    bus_a.wr_en  = we;
    bus_a.wr_ch  = ch;
    bus_a.wr_inc = inc;
    bus_a.sync   = s;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_inc[i]   = init_a[i];
        m_align[i] = e;
      end
      m_restart = e;
    end else begin
      if (we && (ch < 2'd3)) begin
        if (m_inc[ch] != inc) m_align[ch] = e;
        m_inc[ch] = inc;
        m_restart = e;
      end
      if (s) begin
        for (int i = 0; i < 3; i++) m_align[i] = e;
        m_restart = e;
      end
    end
    sb.push_back(predict(e));
  endtask

  task automatic checkOutput(input int run);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard run%0d: no expected entry queued", run);
    end else begin
      x = sb.pop_front();
      if (bus_a.ce === x.ce && bus_a.tgl === x.tgl && bus_a.locked === x.locked) begin
        passed++;
      end else begin
        $display("[TB] FAIL sb run%0d edge%0d: got ce=%b tgl=%b locked=%b, expected ce=%b tgl=%b locked=%b",
                 run, x.edge_n, bus_a.ce, bus_a.tgl, bus_a.locked, x.ce, x.tgl, x.locked);
      end
    end
  endtask

  task automatic doRun(input int run, input int n_edges);
    logic        r;
    logic        we;
    logic        s;
    logic [1:0]  ch;
    logic [31:0] inc;
    int          hit;
    int          cnt0;
    int          cnt1;
    cnt0 = 0;
    cnt1 = 0;
    rst_a        = 1'b1;
    bus_a.wr_en  = 1'b0;
    bus_a.wr_ch  = 2'd0;
    bus_a.wr_inc = 32'h0;
    bus_a.sync   = 1'b0;
    tick();
    tick();
    check("reset_state", run, 0, {28'h0, bus_a.locked, bus_a.tgl, bus_a.ce}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      m_inc[i]   = init_a[i];
      m_align[i] = 0;
    end
    m_restart = 0;
    for (int e = 1; e <= n_edges; e++) begin
      r   = 1'b0;
      we  = 1'b0;
      s   = 1'b0;
      ch  = 2'd0;
      inc = 32'h0;
      hit = -1;
      for (int k = 0; k < NV; k++) begin
        if (vecs[k].run == run && vecs[k].edge_n == e) hit = k;
      end
      if (hit >= 0) begin
        r   = vecs[hit].rst;
        we  = vecs[hit].wr_en;
        ch  = vecs[hit].wr_ch;
        inc = vecs[hit].wr_inc;
        s   = vecs[hit].sync;
      end
      applyStimulus(e, r, we, ch, inc, s);
      tick();
      checkOutput(run);
      if (hit >= 0) begin
        check("vec_ce", run, e, {29'h0, bus_a.ce}, {29'h0, vecs[hit].exp_ce});
        check("vec_tgl_locked", run, e, {28'h0, bus_a.locked, bus_a.tgl},
              {28'h0, vecs[hit].exp_locked, vecs[hit].exp_tgl});
      end
      if (bus_a.ce[0]) cnt0++;
      if (bus_a.ce[1]) cnt1++;
    end
    if (run == 0) begin
      check("ch0_pulse_count", run, n_edges, cnt0, 16);
      check("ch1_pulse_count", run, n_edges, cnt1, 32);
    end
  endtask

  initial begin
    int   pulses0 [$];
    int   cnt1;
    int   cnt2;
    int   exp_pos [3];

    init_a = '{QTR, HALF, 32'h0};
    vecs[0] = '{1, 40, 1'b0, 1'b1, 2'd0, QTR,   1'b0, 3'b011, 3'b000, 1'b0};
    vecs[1] = '{1, 60, 1'b0, 1'b1, 2'd3, 32'h0, 1'b0, 3'b011, 3'b001, 1'b1};
    vecs[2] = '{2, 21, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 3'b000, 3'b000, 1'b0};
    vecs[3] = '{3, 10, 1'b0, 1'b1, 2'd2, HALF,  1'b1, 3'b000, 3'b000, 1'b0};
    vecs[4] = '{4, 10, 1'b0, 1'b1, 2'd2, QTR,   1'b0, 3'b010, 3'b010, 1'b0};
    vecs[5] = '{4, 30, 1'b1, 1'b1, 2'd2, HALF,  1'b0, 3'b000, 3'b000, 1'b0};

    rst_b        = 1'b1;
    bus_b.wr_en  = 1'b0;
    bus_b.wr_ch  = 2'd0;
    bus_b.wr_inc = 8'h0;
    bus_b.sync   = 1'b0;

    doRun(0, 64);
    doRun(1, 70);
    doRun(2, 40);
    doRun(3, 30);
    doRun(4, 50);

    // 8-bit instance: inc=3 on ch0 (written at edge 1) and inc=0xFF on ch2 (written at edge 2)
    exp_pos = '{87, 172, 257};
    cnt1 = 0;
    cnt2 = 0;
    tick();
    tick();
    check("b_reset_state", 5, 0, {28'h0, bus_b.locked, bus_b.tgl, bus_b.ce}, 32'h0);
    rst_b = 1'b0;
    for (int e = 1; e <= 260; e++) begin
      bus_b.wr_en  = (e == 1) || (e == 2);
      bus_b.wr_ch  = (e == 1) ? 2'd0 : 2'd2;
      bus_b.wr_inc = (e == 1) ? 8'd3 : 8'hFF;
      tick();
      if (bus_b.ce[0]) pulses0.push_back(e);
      if (bus_b.ce[1]) cnt1++;
      if (e >= 3 && e <= 258 && bus_b.ce[2]) cnt2++;
    end
    check("b_ch0_pulse_count", 5, 260, pulses0.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < pulses0.size()) check("b_ch0_pulse_edge", 5, k, pulses0[k], exp_pos[k]);
    end
    check("b_ch1_pulse_count", 5, 260, cnt1, 130);
    check("b_ch2_nearfull_count", 5, 258, cnt2, 255);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/de0_cken_gen.md
# de0_cken_gen

Parametrised multi-channel clock-enable generator. It is the successor to the fixed-ratio PLL wrapper on the DE0 board. From one system clock it produces CHANNELS independent fractional-rate enable strobes, each with a toggle output at half the strobe rate. Each channel uses its own phase accumulator, and channels can be retuned at run time without glitches. A `locked` flag models PLL lock/relock behaviour for downstream logic.

## Interface
Parameters:
- CHANNELS, 3, number of output channels (1..16)
- ACC_W, 32, phase accumulator and increment width (≥ 4)
- LOCK_CYCLES, 16, settle cycles before `locked` asserts (≥ 1)
- INC_INIT, {32'h0, 32'h8000_0000, 32'h4000_0000}, packed reset increments, CHANNELS*ACC_W bits, channel 0 in the LSBs

Ports:
- clkin  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  increment write strobe
- wr_ch  in  max(1,$clog2(CHANNELS))  target channel of the write
- wr_inc  in  ACC_W  new phase increment
- sync  in  1  phase-align all channels
- ce  out  CHANNELS  one-cycle enable pulses, registered
- tgl  out  CHANNELS  divided square wave; toggles on each ce pulse, registered
- locked  out  1  high when configuration has been stable ≥ LOCK_CYCLES cycles

## Operation
- Each channel i has inc[i] (ACC_W bits) and acc[i] (ACC_W bits).
- Per cycle: {carry, sum} = acc[i] + inc[i] (ACC_W+1 bits); acc[i] <= sum; ce[i] <= carry.
- Strobe rate: f_ce = f_clkin · inc/2^ACC_W. inc = 0 stops the channel: ce stays 0 and tgl holds its value.
- tgl[i] <= tgl[i] ^ carry, so tgl frequency is f_ce/2.
- Write: wr_en=1 and wr_ch < CHANNELS gives inc[wr_ch] <= wr_inc. The accumulator is not cleared, so phase stays continuous. If wr_ch ≥ CHANNELS the write is ignored entirely, including the lock restart.
- sync=1: all acc <= 0, tgl <= 0, ce <= 0. sync has priority over accumulation.
- sync together with a valid write: both apply. inc is updated and acc is cleared.
- Lock counter lcnt (width $clog2(LOCK_CYCLES+1)):
  - It is set to 0 on reset, on a valid write, or on sync.
  - Otherwise it increments and saturates at LOCK_CYCLES.
  - locked <= (lcnt_next == LOCK_CYCLES).
- ce and tgl keep running while locked=0. Consumers gate on locked.

## Timing
- Reset values: acc=0, inc=INC_INIT, ce=0, tgl=0, lcnt=0, locked=0.
- Edge 1 is the first rising edge with rst=0.
- Accumulation starts at edge 1. A channel with inc=2^(ACC_W-2) has ce high after edges 4, 8, 12, and so on.
- Write latency: the new inc is used from the edge after the write edge. The sum computed on the write edge uses the old inc.
- sync edge: ce=0 after that edge. Accumulation resumes from 0 on the following edge.
- locked first rises after edge LOCK_CYCLES following reset release. It falls after the edge that accepts a write or sync, and rises again LOCK_CYCLES edges later.
- Back-to-back writes each restart lcnt. locked stays low until LOCK_CYCLES quiet cycles have passed.
- rst mid-operation: all state returns to reset values on that edge. Writes and sync in the same cycle are discarded.
- Wrap-around: acc wraps modulo 2^ACC_W. The residue is kept, so the long-term rate is exact (no cumulative drift).
- inc = 2^ACC_W−1 gives ce high on all cycles except one in every 2^ACC_W.

## Test plan
- Reset defaults, ACC_W=32: over 64 cycles, ch0 pulses every 4 cycles (first after edge 4, 16 pulses) and ch1 every 2 cycles (32 pulses). ch2 ce=0 and tgl=0 throughout. tgl0 period is 8 cycles.
- Fractional rate, ACC_W=8: write inc=3 to ch0, then run 256 cycles after the write takes effect -> exactly 3 ce pulses, spaced 85 or 86 cycles apart.
- Lock timing, LOCK_CYCLES=16: locked=0 through edge 15 and 1 after edge 16. Write at edge 40 -> locked=0 after edge 40, 1 after edge 56. wr_ch=3 (invalid) at edge 60 -> locked stays 1 and no inc changes.
- Sync alignment: with ch0 inc=2^30 and ch1 inc=2^31 running with different phases, assert sync at edge 21 -> all ce=0 and tgl=0 after edge 21. Next pulses: ch1 after edge 23, ch0 after edge 25.
- Simultaneous sync + write (ch2, inc=2^31) at edge 10 -> acc cleared, ch2 first ce after edge 12, locked low until after edge 26.
- Mid-operation reset: rst at edge 30 with wr_en=1 -> after edge 30, inc equals INC_INIT (write discarded), all outputs 0, and the sequence then matches the first scenario.
